// File: rtl/param_sq_wave_gen.sv
// -----------------------------------------------------------------------------
// param_sq_wave_gen
//   Multi-voice square-wave sample generator. Each voice owns a phase
//   accumulator, a frequency control word (FCW) and a duty mode. On every
//   next_sample pulse the levels of all voices are summed into the registered
//   output code and every accumulator advances by its FCW. Four debounced
//   button pulses tune the currently selected voice.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   next_sample  single-cycle pulse: produce the next sample
//   buttons[0]   FCW up   (saturates at 2^(ACC_WIDTH-1)-1)
//   buttons[1]   FCW down (saturates at 0)
//   buttons[2]   select next voice (wraps)
//   buttons[3]   cycle duty of selected voice: 50% -> 25% -> 12.5% -> 50%
//   code         registered mixed sample code
//   leds         {duty of selected voice, selected voice index}
// -----------------------------------------------------------------------------
module param_sq_wave_gen #(
  parameter int unsigned CODE_WIDTH = 10,
  parameter int unsigned VOICES     = 2,   // 1, 2 or 4
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned INIT_FCW   = 60473,
  parameter int unsigned FCW_STEP   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  next_sample,
  input  logic [3:0]            buttons,
  output logic [CODE_WIDTH-1:0] code,
  output logic [3:0]            leds
);

  typedef enum logic [1:0] {
    DUTY_50 = 2'd0,
    DUTY_25 = 2'd1,
    DUTY_12 = 2'd2
  } duty_e;

  // Per-voice amplitude chosen so that VOICES voices at full level can never
  // overflow the code register.
  localparam logic [CODE_WIDTH-1:0] HIGH     = CODE_WIDTH'((2 ** CODE_WIDTH) / VOICES - 1);
  localparam logic [ACC_WIDTH:0]    FCW_MAX  = (ACC_WIDTH + 1)'((longint'(1) << (ACC_WIDTH - 1)) - 1);
  localparam logic [ACC_WIDTH:0]    STEP     = (ACC_WIDTH + 1)'(FCW_STEP);
  localparam logic [ACC_WIDTH-1:0]  FCW_RST  = ACC_WIDTH'(INIT_FCW);
  localparam logic [1:0]            SEL_LAST = 2'(VOICES - 1);

  logic [ACC_WIDTH-1:0]  acc_q  [VOICES];
  logic [ACC_WIDTH-1:0]  acc_d  [VOICES];
  logic [ACC_WIDTH-1:0]  fcw_q  [VOICES];
  logic [ACC_WIDTH-1:0]  fcw_d  [VOICES];
  duty_e                 duty_q [VOICES];
  duty_e                 duty_d [VOICES];
  logic [1:0]            sel_q, sel_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;

  logic [VOICES-1:0]     voice_on;
  logic [CODE_WIDTH-1:0] sample_sum;
  duty_e                 duty_sel;

  // Saturating FCW arithmetic, done one bit wider so the carry is visible.
  function automatic logic [ACC_WIDTH-1:0] fcw_up(input logic [ACC_WIDTH-1:0] f);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, f} + STEP;
    return (s > FCW_MAX) ? FCW_MAX[ACC_WIDTH-1:0] : s[ACC_WIDTH-1:0];
  endfunction

  function automatic logic [ACC_WIDTH-1:0] fcw_down(input logic [ACC_WIDTH-1:0] f);
    return ({1'b0, f} < STEP) ? '0 : f - STEP[ACC_WIDTH-1:0];
  endfunction

  // A voice is high while the top 1/2/3 accumulator bits are all zero;
  // a zero FCW mutes the voice whatever phase it was frozen at.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment,
    // otherwise the tool infers a latch for the paths that skip it.
    voice_on   = '0;
    sample_sum = '0;
    for (int v = 0; v < int'(VOICES); v++) begin
      unique case (duty_q[v])
        DUTY_50: voice_on[v] = ~acc_q[v][ACC_WIDTH-1];
        DUTY_25: voice_on[v] = (acc_q[v][ACC_WIDTH-1 -: 2] == 2'b00);
        default: voice_on[v] = (acc_q[v][ACC_WIDTH-1 -: 3] == 3'b000);
      endcase
      if (voice_on[v] && (fcw_q[v] != '0)) begin
        sample_sum = sample_sum + HIGH;
      end
    end
  end

  // Next-state logic. Buttons act on the voice selected before this edge, and
  // the accumulators always advance with the pre-edge FCW.
  always_comb begin
    code_d = next_sample ? sample_sum : code_q;
    sel_d  = sel_q;
    if (buttons[2]) begin
      sel_d = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
    end
    for (int v = 0; v < int'(VOICES); v++) begin
      acc_d[v]  = next_sample ? acc_q[v] + fcw_q[v] : acc_q[v];
      fcw_d[v]  = fcw_q[v];
      duty_d[v] = duty_q[v];
      if (sel_q == 2'(v)) begin
        if (buttons[0] && !buttons[1]) begin
          fcw_d[v] = fcw_up(fcw_q[v]);
        end else if (buttons[1] && !buttons[0]) begin
          fcw_d[v] = fcw_down(fcw_q[v]);
        end
        if (buttons[3]) begin
          unique case (duty_q[v])
            DUTY_50: duty_d[v] = DUTY_25;
            DUTY_25: duty_d[v] = DUTY_12;
            default: duty_d[v] = DUTY_50;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these per-voice arrays are plain registers, not a RAM, so they
      // are reset like any other flop.
      for (int v = 0; v < int'(VOICES); v++) begin
        acc_q[v]  <= '0;
        fcw_q[v]  <= FCW_RST;
        duty_q[v] <= DUTY_50;
      end
      sel_q  <= '0;
      code_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      for (int v = 0; v < int'(VOICES); v++) begin
        acc_q[v]  <= acc_d[v];
        fcw_q[v]  <= fcw_d[v];
        duty_q[v] <= duty_d[v];
      end
      sel_q  <= sel_d;
      code_q <= code_d;
    end
  end

  always_comb begin
    duty_sel = DUTY_50;
    for (int v = 0; v < int'(VOICES); v++) begin
      if (sel_q == 2'(v)) begin
        duty_sel = duty_q[v];
      end
    end
  end

  assign leds = {duty_sel, sel_q};
  assign code = code_q;

endmodule

// File: tb/tb_param_sq_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_param_sq_wave_gen
//   Two instances share clk/rst: dut_a (INIT_FCW = 2^21, coarse step) carries
//   the waveform, duty, select, reset and randomized tests against a
//   behavioural model; dut_b (INIT_FCW = FCW_STEP = 256) carries the FCW
//   saturation scenario.
// -----------------------------------------------------------------------------
module tb_param_sq_wave_gen;

  localparam int     A_V     = 2;
  localparam int     A_ACC   = 24;
  localparam int     A_INIT  = 2 ** 21;
  localparam int     A_STEP  = 2 ** 18;
  localparam int     A_HIGH  = 511;
  localparam longint A_MAX   = (longint'(1) << (A_ACC - 1)) - 1;
  localparam longint A_MOD   = longint'(1) << A_ACC;
  localparam int     N_RAND  = 10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_ns = 1'b0;
  logic [3:0] a_btn = 4'b0;
  logic [9:0] a_code;
  logic [3:0] a_leds;
  logic       b_ns = 1'b0;
  logic [3:0] b_btn = 4'b0;
  logic [9:0] b_code;
  logic [3:0] b_leds;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state for dut_a.
  longint m_acc  [A_V];
  longint m_fcw  [A_V];
  int     m_duty [A_V];
  int     m_sel;
  int     m_code;

  param_sq_wave_gen #(
    .CODE_WIDTH(10), .VOICES(A_V), .ACC_WIDTH(A_ACC),
    .INIT_FCW(A_INIT), .FCW_STEP(A_STEP)
  ) dut_a (
    .clk(clk), .rst(rst), .next_sample(a_ns), .buttons(a_btn),
    .code(a_code), .leds(a_leds)
  );

  param_sq_wave_gen #(
    .CODE_WIDTH(10), .VOICES(2), .ACC_WIDTH(24),
    .INIT_FCW(256), .FCW_STEP(256)
  ) dut_b (
    .clk(clk), .rst(rst), .next_sample(b_ns), .buttons(b_btn),
    .code(b_code), .leds(b_leds)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int v = 0; v < A_V; v++) begin
      m_acc[v]  = 0;
      m_fcw[v]  = A_INIT;
      m_duty[v] = 0;
    end
    m_sel  = 0;
    m_code = 0;
  endtask

  // One clock edge of the reference: sample from old phase, then advance
  // phase with old FCW, then apply buttons to the old selection.
  task automatic model_edge(input logic ns, input logic [3:0] btn);
    int cnt;
    cnt = 0;
    if (ns) begin
      for (int v = 0; v < A_V; v++) begin
        // high fraction of the period is 1/2, 1/4, 1/8 for duty 0, 1, 2
        if (m_fcw[v] != 0 && m_acc[v] < (A_MOD >> (m_duty[v] + 1))) cnt++;
      end
      m_code = cnt * A_HIGH;
      for (int v = 0; v < A_V; v++) m_acc[v] = (m_acc[v] + m_fcw[v]) % A_MOD;
    end
    if (btn[0] && !btn[1])
      m_fcw[m_sel] = (m_fcw[m_sel] + A_STEP > A_MAX) ? A_MAX : m_fcw[m_sel] + A_STEP;
    if (btn[1] && !btn[0])
      m_fcw[m_sel] = (m_fcw[m_sel] < A_STEP) ? 0 : m_fcw[m_sel] - A_STEP;
    if (btn[3]) m_duty[m_sel] = (m_duty[m_sel] + 1) % 3;
    if (btn[2]) m_sel = (m_sel + 1) % A_V;
  endtask

  // Drive dut_a for one cycle; returns 1 time unit after the edge.
  task automatic tick(input logic ns, input logic [3:0] btn);
    a_ns  = ns;
    a_btn = btn;
    @(posedge clk);
    model_edge(ns, btn);
    #1;
    a_ns  = 1'b0;
    a_btn = 4'b0;
  endtask

  task automatic tick_b(input logic ns, input logic [3:0] btn);
    b_ns  = ns;
    b_btn = btn;
    tick(1'b0, 4'b0);
    b_ns  = 1'b0;
    b_btn = 4'b0;
  endtask

  // Reset with junk on the inputs, released mid-cycle.
  task automatic apply_reset();
    rst   = 1'b1;
    a_ns  = 1'($urandom);
    a_btn = 4'($urandom);
    b_ns  = 1'($urandom);
    b_btn = 4'($urandom);
    repeat (2) @(posedge clk);
    #4;
    a_ns  = 1'b0;
    a_btn = 4'b0;
    b_ns  = 1'b0;
    b_btn = 4'b0;
    rst   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    a_ns  = 1'b1;
    a_btn = 4'b1111;
    b_ns  = 1'b1;
    b_btn = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (a_code !== 10'd0) begin
      n_fail++; $display("FAIL reset_code_a: got %0d expected 0", a_code);
    end
    n_checks++;
    if (a_leds !== 4'b0000) begin
      n_fail++; $display("FAIL reset_leds_a: got %b expected 0000", a_leds);
    end
    n_checks++;
    if (b_code !== 10'd0) begin
      n_fail++; $display("FAIL reset_code_b: got %0d expected 0", b_code);
    end
    apply_reset();
    n_checks++;
    if (a_code !== 10'd0 || a_leds !== 4'b0000) begin
      n_fail++; $display("FAIL post_reset_idle: got code %0d leds %b expected 0/0000", a_code, a_leds);
    end
  endtask

  task automatic test_basic_wave();
    int exp_codes[8] = '{1022, 1022, 1022, 1022, 0, 0, 0, 0};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 4'b0);
      n_checks++;
      if (a_code !== 10'(exp_codes[i])) begin
        n_fail++; $display("FAIL basic_wave[%0d]: got %0d expected %0d", i, a_code, exp_codes[i]);
      end
    end
  endtask

  task automatic test_duty();
    int exp_codes[8] = '{1022, 1022, 511, 511, 0, 0, 0, 0};
    apply_reset();
    tick(1'b0, 4'b1000);
    n_checks++;
    if (a_leds !== 4'b0100) begin
      n_fail++; $display("FAIL duty_leds: got %b expected 0100", a_leds);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 4'b0);
      n_checks++;
      if (a_code !== 10'(exp_codes[i])) begin
        n_fail++; $display("FAIL duty_wave[%0d]: got %0d expected %0d", i, a_code, exp_codes[i]);
      end
    end
  endtask

  task automatic test_select();
    int exp_codes[8] = '{1022, 1022, 511, 511, 0, 0, 0, 0};
    apply_reset();
    tick(1'b0, 4'b0100);
    n_checks++;
    if (a_leds !== 4'b0001) begin
      n_fail++; $display("FAIL select_one: got %b expected 0001", a_leds);
    end
    tick(1'b0, 4'b1000);
    n_checks++;
    if (a_leds !== 4'b0101) begin
      n_fail++; $display("FAIL select_duty_v1: got %b expected 0101", a_leds);
    end
    tick(1'b0, 4'b0100);
    n_checks++;
    if (a_leds !== 4'b0000) begin
      n_fail++; $display("FAIL select_wrap: got %b expected 0000", a_leds);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 4'b0);
      n_checks++;
      if (a_code !== 10'(exp_codes[i])) begin
        n_fail++; $display("FAIL select_wave[%0d]: got %0d expected %0d", i, a_code, exp_codes[i]);
      end
    end
  endtask

  // Duty press coinciding with a sample must not affect that sample.
  task automatic test_same_cycle();
    apply_reset();
    tick(1'b1, 4'b0);
    tick(1'b1, 4'b0);
    tick(1'b1, 4'b1000);
    n_checks++;
    if (a_code !== 10'd1022) begin
      n_fail++; $display("FAIL same_cycle_old_duty: got %0d expected 1022", a_code);
    end
    tick(1'b1, 4'b0);
    n_checks++;
    if (a_code !== 10'd511) begin
      n_fail++; $display("FAIL same_cycle_new_duty: got %0d expected 511", a_code);
    end
  endtask

  task automatic test_fcw_saturation();
    apply_reset();
    tick_b(1'b0, 4'b0010);
    tick_b(1'b0, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      tick_b(1'b1, 4'b0);
      n_checks++;
      if (b_code !== 10'd511) begin
        n_fail++; $display("FAIL sat_silent[%0d]: got %0d expected 511", i, b_code);
      end
    end
    tick_b(1'b0, 4'b0011);
    tick_b(1'b1, 4'b0);
    n_checks++;
    if (b_code !== 10'd511) begin
      n_fail++; $display("FAIL sat_both_buttons: got %0d expected 511", b_code);
    end
    tick_b(1'b0, 4'b0001);
    tick_b(1'b1, 4'b0);
    n_checks++;
    if (b_code !== 10'd1022) begin
      n_fail++; $display("FAIL sat_up_again: got %0d expected 1022", b_code);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick(1'b0, 4'b0100);
    tick(1'b0, 4'b1000);
    tick(1'b1, 4'b0);
    tick(1'b1, 4'b0);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (a_code !== 10'd0 || a_leds !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset: got code %0d leds %b expected 0/0000", a_code, a_leds);
    end
    #2;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    tick(1'b1, 4'b0);
    n_checks++;
    if (a_code !== 10'd1022) begin
      n_fail++; $display("FAIL async_reset_first_sample: got %0d expected 1022", a_code);
    end
  endtask

  task automatic test_random();
    int         gap;
    logic [3:0] btn;
    logic [3:0] exp_leds;
    apply_reset();
    for (int s = 0; s < N_RAND; s++) begin
      gap = $urandom_range(2, 9);
      for (int c = 0; c < gap; c++) begin
        btn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
        tick(c == gap - 1, btn);
        exp_leds = {2'(m_duty[m_sel]), 2'(m_sel)};
        n_checks++;
        if (a_code !== 10'(m_code)) begin
          n_fail++; $display("FAIL random_code s=%0d c=%0d: got %0d expected %0d", s, c, a_code, m_code);
        end
        n_checks++;
        if (a_leds !== exp_leds) begin
          n_fail++; $display("FAIL random_leds s=%0d c=%0d: got %b expected %b", s, c, a_leds, exp_leds);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_wave();
    test_duty();
    test_select();
    test_same_cycle();
    test_fcw_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
